multi_mode_ff_bank: RTL and testbench

//  Parametrised bank of WIDTH flip-flops. All channels share one run-time mode: SR, JK, D or T.

---
 rtl/multi_mode_ff_bank.sv | 163 ++++++++++++++++
 tb/tb_multi_mode_ff_bank.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_mode_ff_bank.sv
// multi_mode_ff_bank: WIDTH-channel flip-flop bank with a shared run-time mode
// (SR, JK, D or T), synchronous parallel load, update enable and sticky
// flagging of the SR a=b=1 combination. The SR 1/1 result is fixed at
// elaboration by SR_INV_POLICY and is never driven to X.
// Optional feature: define MMFF_CHG_CNT_EN to add a saturating counter of
// bit changes (cnt_clr input, chg_cnt output).
module multi_mode_ff_bank #(
  parameter int WIDTH         = 8,
  parameter int SR_INV_POLICY = 0,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             err_clr,
`ifdef MMFF_CHG_CNT_EN
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] chg_cnt,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] inv_mask,
  output logic             inv_err
);

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_e;

  // SR a=b=1 resolution choices
  localparam int POL_HOLD  = 0;
  localparam int POL_SET   = 1;
  localparam int POL_RESET = 2;
  localparam int POL_TGL   = 3;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] qn_q, qn_d;
  logic [WIDTH-1:0] inv_mask_q, inv_mask_d;
  logic             inv_err_q, inv_err_d;
  mode_e            mode_s;

  assign mode_s = mode_e'(mode);

  // Next state of every channel: load beats enable, enable gates the mode logic.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves it
    // unassigned and no latch is inferred.
    q_d        = q_q;
    inv_mask_d = '0;
    if (load) begin
      q_d = load_val;
    end else if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        unique case (mode_s)
          MODE_SR: begin
            unique case ({a[i], b[i]})
              2'b00: q_d[i] = q_q[i];
              2'b01: q_d[i] = 1'b0;
              2'b10: q_d[i] = 1'b1;
              default: begin
                inv_mask_d[i] = 1'b1;
                case (SR_INV_POLICY)
                  POL_SET:   q_d[i] = 1'b1;
                  POL_RESET: q_d[i] = 1'b0;
                  POL_TGL:   q_d[i] = ~q_q[i];
                  POL_HOLD:  q_d[i] = q_q[i];
                  default:   q_d[i] = q_q[i];
                endcase
              end
            endcase
          end
          MODE_JK: begin
            unique case ({a[i], b[i]})
              2'b00:   q_d[i] = q_q[i];
              2'b01:   q_d[i] = 1'b0;
              2'b10:   q_d[i] = 1'b1;
              default: q_d[i] = ~q_q[i];
            endcase
          end
          MODE_D:  q_d[i] = a[i];
          default: q_d[i] = q_q[i] ^ a[i];
        endcase
      end
    end
    qn_d = ~q_d;
  end

  // Sticky error: a new invalid combination wins over a simultaneous clear.
  always_comb begin
    inv_err_d = inv_err_q;
    if (err_clr)     inv_err_d = 1'b0;
    if (|inv_mask_d) inv_err_d = 1'b1;
  end

  // State, complement and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      q_q        <= '0;
      qn_q       <= '1;
      inv_mask_q <= '0;
      inv_err_q  <= 1'b0;
    end else begin
      q_q        <= q_d;
      qn_q       <= qn_d;
      inv_mask_q <= inv_mask_d;
      inv_err_q  <= inv_err_d;
    end
  end

  assign q        = q_q;
  assign qn       = qn_q;
  assign inv_mask = inv_mask_q;
  assign inv_err  = inv_err_q;

`ifdef MMFF_CHG_CNT_EN
  // Sum is wide enough for the counter plus a full-width popcount, so the
  // saturation compare never sees a wrapped value.
  localparam int POP_W = $clog2(WIDTH + 1);
  localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;

  logic [CNT_W-1:0] chg_cnt_q, chg_cnt_d;
  logic [WIDTH-1:0] diff;
  logic [POP_W-1:0] pop;
  logic [SUM_W-1:0] sum;

  assign diff = q_d ^ q_q;

  // Count changed bits this edge and saturate; clear has priority.
  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + POP_W'(diff[i]);
    end
    sum = SUM_W'(chg_cnt_q) + SUM_W'(pop);
    if (cnt_clr) begin
      chg_cnt_d = '0;
    end else if (sum > SUM_W'({CNT_W{1'b1}})) begin
      chg_cnt_d = '1;
    end else begin
      chg_cnt_d = sum[CNT_W-1:0];
    end
  end

  // Change counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chg_cnt_q <= '0;
    else        chg_cnt_q <= chg_cnt_d;
  end

  assign chg_cnt = chg_cnt_q;
`endif

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// Directed bench for multi_mode_ff_bank. Four instances, one per SR_INV_POLICY,
// share all inputs; most scenarios check the policy-0 instance. The change
// counter scenario runs only when MMFF_CHG_CNT_EN is defined.
module tb_multi_mode_ff_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] a = '0, b = '0, load_val = '0;
  logic       load = 1'b0, err_clr = 1'b0;
  logic       cnt_clr = 1'b0;

  logic [7:0] q_o [4];
  logic [7:0] qn_o [4];
  logic [7:0] im_o [4];
  logic       ie_o [4];
  logic [3:0] cnt_o [4];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar p = 0; p < 4; p++) begin : g_dut
    multi_mode_ff_bank #(.WIDTH(8), .SR_INV_POLICY(p), .CNT_W(4)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .mode     (mode),
      .a        (a),
      .b        (b),
      .load     (load),
      .load_val (load_val),
      .err_clr  (err_clr),
`ifdef MMFF_CHG_CNT_EN
      .cnt_clr  (cnt_clr),
      .chg_cnt  (cnt_o[p]),
`endif
      .q        (q_o[p]),
      .qn       (qn_o[p]),
      .inv_mask (im_o[p]),
      .inv_err  (ie_o[p])
    );
  end

`ifndef MMFF_CHG_CNT_EN
  initial for (int p = 0; p < 4; p++) cnt_o[p] = '0;
`endif

  // One rising edge; returns on the following falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    en = 1'b0; load = 1'b0; err_clr = 1'b0; cnt_clr = 1'b0; a = '0; b = '0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (q_o[0] !== 8'h00) begin n_bad++; $display("FAIL rst_q got %h want 00", q_o[0]); end
    n_cmp++; if (qn_o[0] !== 8'hFF) begin n_bad++; $display("FAIL rst_qn got %h want FF", qn_o[0]); end
    n_cmp++; if (im_o[0] !== 8'h00 || ie_o[0] !== 1'b0) begin n_bad++; $display("FAIL rst_flags got %h/%b want 00/0", im_o[0], ie_o[0]); end
    rst_n = 1'b1;
    // make inv_err sticky high, then load 0xA5
    en = 1'b1; mode = 2'b00; a = 8'h01; b = 8'h01;
    step();
    n_cmp++; if (ie_o[0] !== 1'b1) begin n_bad++; $display("FAIL pre_rst_err got %b want 1", ie_o[0]); end
    a = '0; b = '0; load = 1'b1; load_val = 8'hA5;
    step();
    load = 1'b0; en = 1'b0;
    n_cmp++; if (q_o[0] !== 8'hA5 || ie_o[0] !== 1'b1) begin n_bad++; $display("FAIL load_a5 got %h/%b want A5/1", q_o[0], ie_o[0]); end
    // asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (q_o[0] !== 8'h00 || qn_o[0] !== 8'hFF) begin n_bad++; $display("FAIL async_rst q/qn got %h/%h want 00/FF", q_o[0], qn_o[0]); end
    n_cmp++; if (ie_o[0] !== 1'b0) begin n_bad++; $display("FAIL async_rst_err got %b want 0", ie_o[0]); end
`ifdef MMFF_CHG_CNT_EN
    n_cmp++; if (cnt_o[0] !== 4'd0) begin n_bad++; $display("FAIL async_rst_cnt got %0d want 0", cnt_o[0]); end
`endif
    #1 rst_n = 1'b1;
    step();
    n_cmp++; if (q_o[0] !== 8'h00) begin n_bad++; $display("FAIL post_rst_hold got %h want 00", q_o[0]); end
  endtask

  task automatic test_sr();
    logic [7:0] exp_q [4];
    exp_q[0] = 8'h0F; exp_q[1] = 8'h0F; exp_q[2] = 8'h0E; exp_q[3] = 8'h0E;
    en = 1'b1; mode = 2'b00; a = 8'h0F; b = 8'hF0;
    step();
    for (int p = 0; p < 4; p++) begin
      n_cmp++; if (q_o[p] !== 8'h0F) begin n_bad++; $display("FAIL sr_set_reset p%0d got %h want 0F", p, q_o[p]); end
    end
    a = 8'h01; b = 8'h01;
    step();
    for (int p = 0; p < 4; p++) begin
      n_cmp++; if (q_o[p] !== exp_q[p] || qn_o[p] !== ~exp_q[p]) begin n_bad++; $display("FAIL sr_inv p%0d q/qn got %h/%h want %h", p, q_o[p], qn_o[p], exp_q[p]); end
      n_cmp++; if (im_o[p] !== 8'h01 || ie_o[p] !== 1'b1) begin n_bad++; $display("FAIL sr_inv_flags p%0d got %h/%b want 01/1", p, im_o[p], ie_o[p]); end
    end
    a = '0; b = '0; err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    for (int p = 0; p < 4; p++) begin
      n_cmp++; if (im_o[p] !== 8'h00 || ie_o[p] !== 1'b0 || q_o[p] !== exp_q[p]) begin n_bad++; $display("FAIL sr_clr p%0d got q=%h mask=%h err=%b want %h/00/0", p, q_o[p], im_o[p], ie_o[p], exp_q[p]); end
    end
    idle();
  endtask

  task automatic test_jk();
    load = 1'b1; load_val = 8'h0F;
    step();
    load = 1'b0; en = 1'b1; mode = 2'b01; a = 8'hFF; b = 8'hFF;
    step();
    n_cmp++; if (q_o[0] !== 8'hF0 || qn_o[0] !== 8'h0F) begin n_bad++; $display("FAIL jk_toggle q/qn got %h/%h want F0/0F", q_o[0], qn_o[0]); end
    n_cmp++; if (im_o[0] !== 8'h00 || ie_o[0] !== 1'b0) begin n_bad++; $display("FAIL jk_no_flag got %h/%b want 00/0", im_o[0], ie_o[0]); end
    a = 8'h80; b = 8'h01;
    step();
    n_cmp++; if (q_o[0] !== 8'hF0) begin n_bad++; $display("FAIL jk_set_reset got %h want F0", q_o[0]); end
    a = 8'h01; b = 8'h80;
    step();
    n_cmp++; if (q_o[0] !== 8'h71) begin n_bad++; $display("FAIL jk_set_reset2 got %h want 71", q_o[0]); end
    idle();
  endtask

  task automatic test_d_t_enable();
    en = 1'b1; mode = 2'b10; a = 8'h5A; b = 8'hFF;
    step();
    n_cmp++; if (q_o[0] !== 8'h5A) begin n_bad++; $display("FAIL d_mode got %h want 5A", q_o[0]); end
    mode = 2'b11; a = 8'hFF;
    step();
    n_cmp++; if (q_o[0] !== 8'hA5 || qn_o[0] !== 8'h5A) begin n_bad++; $display("FAIL t_mode q/qn got %h/%h want A5/5A", q_o[0], qn_o[0]); end
    en = 1'b0;
    step();
    n_cmp++; if (q_o[0] !== 8'hA5) begin n_bad++; $display("FAIL en_hold got %h want A5", q_o[0]); end
    mode = 2'b00; b = 8'hFF;
    step();
    n_cmp++; if (q_o[0] !== 8'hA5 || im_o[0] !== 8'h00 || ie_o[0] !== 1'b0) begin n_bad++; $display("FAIL en_off_sr got q=%h mask=%h err=%b want A5/00/0", q_o[0], im_o[0], ie_o[0]); end
    idle();
  endtask

  task automatic test_priority();
    load = 1'b1; load_val = 8'h33; en = 1'b1; mode = 2'b00; a = 8'hFF; b = 8'hFF;
    step();
    n_cmp++; if (q_o[0] !== 8'h33 || im_o[0] !== 8'h00 || ie_o[0] !== 1'b0) begin n_bad++; $display("FAIL load_prio got q=%h mask=%h err=%b want 33/00/0", q_o[0], im_o[0], ie_o[0]); end
    load = 1'b0; err_clr = 1'b1; a = 8'h01; b = 8'h01;
    step();
    n_cmp++; if (ie_o[0] !== 1'b1 || im_o[0] !== 8'h01 || q_o[0] !== 8'h33) begin n_bad++; $display("FAIL set_beats_clr got q=%h mask=%h err=%b want 33/01/1", q_o[0], im_o[0], ie_o[0]); end
    a = '0; b = '0; err_clr = 1'b0;
    step();
    n_cmp++; if (ie_o[0] !== 1'b1 || im_o[0] !== 8'h00) begin n_bad++; $display("FAIL err_sticky got mask=%h err=%b want 00/1", im_o[0], ie_o[0]); end
    err_clr = 1'b1;
    step();
    n_cmp++; if (ie_o[0] !== 1'b0) begin n_bad++; $display("FAIL err_clear got %b want 0", ie_o[0]); end
    idle();
  endtask

  task automatic test_back_to_back();
    en = 1'b1; mode = 2'b10; a = 8'h0F;
    step();
    mode = 2'b01; a = 8'hF0; b = 8'h0F;
    step();
    n_cmp++; if (q_o[0] !== 8'hF0) begin n_bad++; $display("FAIL b2b_jk got %h want F0", q_o[0]); end
    mode = 2'b11; a = 8'hFF;
    step();
    n_cmp++; if (q_o[0] !== 8'h0F) begin n_bad++; $display("FAIL b2b_t got %h want 0F", q_o[0]); end
    idle();
  endtask

`ifdef MMFF_CHG_CNT_EN
  task automatic test_chg_cnt();
    load = 1'b1; load_val = 8'h00; cnt_clr = 1'b1;
    step();
    load = 1'b0; cnt_clr = 1'b0;
    n_cmp++; if (cnt_o[0] !== 4'd0 || q_o[0] !== 8'h00) begin n_bad++; $display("FAIL cnt_start got cnt=%0d q=%h want 0/00", cnt_o[0], q_o[0]); end
    en = 1'b1; mode = 2'b10; a = 8'hFF;
    step();
    n_cmp++; if (cnt_o[0] !== 4'd8) begin n_bad++; $display("FAIL cnt_8 got %0d want 8", cnt_o[0]); end
    a = 8'h00;
    step();
    n_cmp++; if (cnt_o[0] !== 4'd15) begin n_bad++; $display("FAIL cnt_sat got %0d want 15", cnt_o[0]); end
    cnt_clr = 1'b1; a = 8'hFF;
    step();
    n_cmp++; if (cnt_o[0] !== 4'd0 || q_o[0] !== 8'hFF) begin n_bad++; $display("FAIL cnt_clr got cnt=%0d q=%h want 0/FF", cnt_o[0], q_o[0]); end
    cnt_clr = 1'b0; en = 1'b0; load = 1'b1; load_val = 8'hF0;
    step();
    n_cmp++; if (cnt_o[0] !== 4'd4) begin n_bad++; $display("FAIL cnt_load got %0d want 4", cnt_o[0]); end
    idle();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sr();
    test_jk();
    test_d_t_enable();
    test_priority();
    test_back_to_back();
`ifdef MMFF_CHG_CNT_EN
    test_chg_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
